// File: rtl/execute_cycle.sv
// Execute stage of the pipelined RV32I core: operand forwarding, ALU, branch resolution, EX/MEM register.
// Optional macro BRANCH_FUNCT3_EN adds funct3E and full RV32I branch conditions (default: beq only).
module execute_cycle #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegwriteE,
    input  logic            ALUsrcE,
    input  logic            MemwriteE,
    input  logic            ResultsrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUcontrolE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCplus4E,
    input  logic [XLEN-1:0] ImmextE,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
`ifdef BRANCH_FUNCT3_EN
    input  logic [2:0]      funct3E,
`endif
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegwriteM,
    output logic            MemwriteM,
    output logic            ResultsrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCplus4M
);

    localparam int unsigned SHW = 5;

    logic [XLEN-1:0] src_a_c, fwd_b_c, src_b_c, alu_res_c;
    logic            zero_c, cond_c;

    logic            regwrite_d, memwrite_d, resultsrc_d;
    logic            regwrite_q, memwrite_q, resultsrc_q;
    logic [4:0]      rd_d, rd_q;
    logic [XLEN-1:0] alu_res_d, alu_res_q;
    logic [XLEN-1:0] wdata_d, wdata_q;
    logic [XLEN-1:0] pcplus4_d, pcplus4_q;

    // Forwarding muxes; 2'b10 feeds back this stage's own registered ALU result
    always_comb begin
        src_a_c = RD1E;
        fwd_b_c = RD2E;
        case (ForwardAE)
            2'b01:   src_a_c = ResultW;
            2'b10:   src_a_c = alu_res_q;
            default: src_a_c = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b_c = ResultW;
            2'b10:   fwd_b_c = alu_res_q;
            default: fwd_b_c = RD2E;
        endcase
        src_b_c = ALUsrcE ? ImmextE : fwd_b_c;
    end

    always_comb begin
        alu_res_c = '0;
        case (ALUcontrolE)
            3'b000:  alu_res_c = src_a_c + src_b_c;
            3'b001:  alu_res_c = src_a_c - src_b_c;
            3'b010:  alu_res_c = src_a_c & src_b_c;
            3'b011:  alu_res_c = src_a_c | src_b_c;
            3'b100:  alu_res_c = src_a_c << src_b_c[SHW-1:0];
            3'b101:  alu_res_c = XLEN'(($signed(src_a_c) < $signed(src_b_c)) ? 1 : 0);
            3'b110:  alu_res_c = src_a_c ^ src_b_c;
            default: alu_res_c = '0;
        endcase
        zero_c = (alu_res_c == '0);
    end

    // Branch condition; comparisons use the forwarded operands, not the ALU result
    always_comb begin
        cond_c = zero_c;
`ifdef BRANCH_FUNCT3_EN
        case (funct3E)
            3'b000:  cond_c = zero_c;
            3'b001:  cond_c = ~zero_c;
            3'b100:  cond_c = ($signed(src_a_c) < $signed(src_b_c));
            3'b101:  cond_c = ~($signed(src_a_c) < $signed(src_b_c));
            3'b110:  cond_c = (src_a_c < src_b_c);
            3'b111:  cond_c = ~(src_a_c < src_b_c);
            default: cond_c = 1'b0;
        endcase
`endif
    end

    assign PCSrcE    = BranchE & cond_c;
    assign PCTargetE = PCE + ImmextE;

    always_comb begin
        regwrite_d  = RegwriteE;
        memwrite_d  = MemwriteE;
        resultsrc_d = ResultsrcE;
        rd_d        = RdE;
        alu_res_d   = alu_res_c;
        wdata_d     = fwd_b_c;
        pcplus4_d   = PCplus4E;
    end

    // EX/MEM pipeline register; reset discards the in-flight instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= 5'd0;
            alu_res_q   <= '0;
            wdata_q     <= '0;
            pcplus4_q   <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            alu_res_q   <= alu_res_d;
            wdata_q     <= wdata_d;
            pcplus4_q   <= pcplus4_d;
        end
    end

    assign RegwriteM  = regwrite_q;
    assign MemwriteM  = memwrite_q;
    assign ResultsrcM = resultsrc_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_res_q;
    assign WriteDataM = wdata_q;
    assign PCplus4M   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; exercises funct3 branches when BRANCH_FUNCT3_EN is defined.
module tb_execute_cycle;

    logic        clk, rst;
    logic        RegwriteE, ALUsrcE, MemwriteE, ResultsrcE, BranchE;
    logic [2:0]  ALUcontrolE;
    logic [31:0] RD1E, RD2E, PCE, PCplus4E, ImmextE, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
`ifdef BRANCH_FUNCT3_EN
    logic [2:0]  funct3E;
`endif
    logic        PCSrcE, RegwriteM, MemwriteM, ResultsrcM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCplus4M;
    logic [4:0]  RdM;

    int n_tests = 0;
    int n_fail  = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegwriteE(RegwriteE), .ALUsrcE(ALUsrcE), .MemwriteE(MemwriteE),
        .ResultsrcE(ResultsrcE), .BranchE(BranchE), .ALUcontrolE(ALUcontrolE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCplus4E(PCplus4E), .ImmextE(ImmextE),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
`ifdef BRANCH_FUNCT3_EN
        .funct3E(funct3E),
`endif
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegwriteM(RegwriteM), .MemwriteM(MemwriteM), .ResultsrcM(ResultsrcM),
        .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCplus4M(PCplus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_m_zero(input string tag);
        check_eq({tag, "_regwrite"},  32'(RegwriteM),  32'd0);
        check_eq({tag, "_memwrite"},  32'(MemwriteM),  32'd0);
        check_eq({tag, "_resultsrc"}, 32'(ResultsrcM), 32'd0);
        check_eq({tag, "_rd"},        32'(RdM),        32'd0);
        check_eq({tag, "_alures"},    ALUResultM,      32'd0);
        check_eq({tag, "_wdata"},     WriteDataM,      32'd0);
        check_eq({tag, "_pcplus4"},   PCplus4M,        32'd0);
    endtask

    initial begin
        rst = 1'b0;
        RegwriteE = 0; ALUsrcE = 0; MemwriteE = 0; ResultsrcE = 0; BranchE = 0;
        ALUcontrolE = 3'b000; RD1E = 0; RD2E = 0; PCE = 0; PCplus4E = 0; ImmextE = 0;
        RdE = 0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0;
`ifdef BRANCH_FUNCT3_EN
        funct3E = 3'b000;
`endif
        #2;
        check_m_zero("por");
        step();
        rst = 1'b1;

        // add with immediate
        RD1E = 32'd5; ImmextE = 32'd7; ALUsrcE = 1; ALUcontrolE = 3'b000;
        RdE = 5'd3; RegwriteE = 1; PCplus4E = 32'h44; ResultsrcE = 1;
        step();
        check_eq("add_imm", ALUResultM, 32'd12);
        check_eq("add_rd", 32'(RdM), 32'd3);
        check_eq("add_regwrite", 32'(RegwriteM), 32'd1);
        check_eq("add_resultsrc", 32'(ResultsrcM), 32'd1);
        check_eq("add_pcplus4", PCplus4M, 32'h44);

        // sub register operands
        ALUsrcE = 0; RD2E = 32'd9; ALUcontrolE = 3'b001; ResultsrcE = 0;
        step();
        check_eq("sub_reg", ALUResultM, 32'hFFFF_FFFC);

        // preload ALUResultM = 100
        RD1E = 32'd100; ImmextE = 32'd0; ALUsrcE = 1; ALUcontrolE = 3'b000;
        step();
        check_eq("preload", ALUResultM, 32'd100);

        // forward A from ALUResultM, B from ResultW
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd40; ALUsrcE = 0;
        step();
        check_eq("fwd_add", ALUResultM, 32'd140);
        check_eq("fwd_wdata_reg", WriteDataM, 32'd40);

        // store data comes from forwarded B even with immediate selected
        ALUsrcE = 1; ImmextE = 32'd7; MemwriteE = 1;
        step();
        check_eq("fwd_imm_add", ALUResultM, 32'd147);
        check_eq("store_wdata", WriteDataM, 32'd40);
        check_eq("store_memwrite", 32'(MemwriteM), 32'd1);

        // asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1 check_m_zero("async_rst");
        step();
        check_m_zero("rst_held");
        // post-reset: ForwardAE=10 must see zero
        ForwardAE = 2'b10; ForwardBE = 2'b00; ALUsrcE = 1; ImmextE = 32'd5;
        ALUcontrolE = 3'b000; MemwriteE = 0; RegwriteE = 0;
        rst = 1'b1;
        #1 check_m_zero("rst_release");
        step();
        check_eq("post_rst_fwd", ALUResultM, 32'd5);

        // branch beq taken / not taken
        ForwardAE = 2'b00; ALUsrcE = 0; PCE = 32'h100; ImmextE = 32'hFFFF_FFF8;
        BranchE = 1; ALUcontrolE = 3'b001; RD1E = 32'd4; RD2E = 32'd4;
        #1;
        check_eq("br_target", PCTargetE, 32'h0000_00F8);
        check_eq("br_taken", 32'(PCSrcE), 32'd1);
        RD2E = 32'd5;
        #1 check_eq("br_not_taken", 32'(PCSrcE), 32'd0);
        RD2E = 32'd4; BranchE = 0;
        #1 check_eq("nobranch_zero", 32'(PCSrcE), 32'd0);

        // ALU coverage
        RD1E = 32'h8000_0000; RD2E = 32'd1; ALUcontrolE = 3'b101;
        step();
        check_eq("slt_ovf", ALUResultM, 32'd1);
        RD1E = 32'd1; RD2E = 32'h8000_0000;
        step();
        check_eq("slt_false", ALUResultM, 32'd0);
        RD1E = 32'd1; ImmextE = 32'h21; ALUsrcE = 1; ALUcontrolE = 3'b100;
        step();
        check_eq("sll_mask", ALUResultM, 32'd2);
        RD1E = 32'hF0F0; RD2E = 32'h0FF0; ALUsrcE = 0; ALUcontrolE = 3'b110;
        step();
        check_eq("xor", ALUResultM, 32'hFF00);
        ALUcontrolE = 3'b010;
        step();
        check_eq("and", ALUResultM, 32'h00F0);
        ALUcontrolE = 3'b011;
        step();
        check_eq("or", ALUResultM, 32'hFFF0);
        ALUcontrolE = 3'b111;
        step();
        check_eq("op111", ALUResultM, 32'd0);

`ifdef BRANCH_FUNCT3_EN
        BranchE = 1; ALUsrcE = 0; ALUcontrolE = 3'b001;
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
        funct3E = 3'b110; #1 check_eq("bltu", 32'(PCSrcE), 32'd0);
        funct3E = 3'b100; #1 check_eq("blt", 32'(PCSrcE), 32'd1);
        funct3E = 3'b010; #1 check_eq("f3_010", 32'(PCSrcE), 32'd0);
        funct3E = 3'b101; #1 check_eq("bge", 32'(PCSrcE), 32'd0);
        funct3E = 3'b111; #1 check_eq("bgeu", 32'(PCSrcE), 32'd1);
        funct3E = 3'b001; #1 check_eq("bne", 32'(PCSrcE), 32'd1);
        funct3E = 3'b000; #1 check_eq("beq_ne", 32'(PCSrcE), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage pipelined RV32I core. Sits directly downstream of the ID/EX register outputs and upstream of the memory stage.
- Applies operand forwarding, performs the ALU operation, and resolves branches (PCSrcE/PCTargetE back to fetch).
- Registers results and control into the EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width (fixed at 32; parameterised for lint only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RegwriteE  in  1  register-write control from ID/EX
- ALUsrcE  in  1  1: SrcB = ImmextE; 0: SrcB = forwarded RD2
- MemwriteE  in  1  store control
- ResultsrcE  in  1  1: load result selected in writeback
- BranchE  in  1  branch instruction
- ALUcontrolE  in  3  ALU operation code
- RD1E, RD2E  in  32 each  register operands
- PCE, PCplus4E, ImmextE  in  32 each  PC, PC+4, extended immediate
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forwarding selects from hazard unit
- ResultW  in  32  writeback result (forward source)
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  32  PCE + ImmextE (combinational)
- RegwriteM, MemwriteM, ResultsrcM  out  1 each  registered control
- RdM  out  5  registered destination
- ALUResultM  out  32  registered ALU result
- WriteDataM  out  32  registered store data
- PCplus4M  out  32  registered PC+4

Behaviour:
- Forward mux A, from ForwardAE:
  - 00 → RD1E
  - 01 → ResultW
  - 10 → ALUResultM (this block's own registered output)
  - 11 → RD1E
- Forward mux B: same encoding, gives fwdB; 00/11 select RD2E.
- SrcB = ALUsrcE ? ImmextE : fwdB. WriteData = fwdB; store data is never the immediate.
- ALU, combinational, 32-bit wrap-around, no carry-out:
  - 000 add
  - 001 sub (A − B)
  - 010 and
  - 011 or
  - 100 sll by SrcB[4:0]
  - 101 slt signed; result 32'd1 or 32'd0
  - 110 xor
  - 111 result 32'd0
- Zero = (ALU result == 0).
- PCSrcE = BranchE & Zero (beq semantics). PCTargetE = PCE + ImmextE, modulo 2^32.
- PCSrcE and PCTargetE have zero latency and are valid in the same cycle as the E inputs.
- EX/MEM register:
  - On posedge clk with rst=1, loads RegwriteE, MemwriteE, ResultsrcE, RdE, ALU result, WriteData, PCplus4E into the *M outputs.
  - Latency is 1 cycle; updates every cycle; no stall or enable.
- Reset: rst=0 asynchronously forces all *M outputs to 0 (RdM=5'd0, 32-bit outputs 32'h0), independent of clk. Mid-operation reset discards the in-flight instruction.
- Registered outputs hold 0 until the first rising edge after rst deasserts.
- ForwardAE=10 taken on the cycle immediately after reset selects 32'h0.
- Branch instructions still propagate their control; MemwriteE/RegwriteE are already 0 for branches from the decoder. No internal gating is applied.
- slt overflow case: A=32'h80000000, B=32'h00000001 → 1 (signed compare, not subtract sign bit).

Optional Feature:
- Macro BRANCH_FUNCT3_EN.
- When defined:
  - Adds input funct3E [2:0].
  - PCSrcE = BranchE & cond, where cond is:
    - 000 beq: Zero
    - 001 bne: ~Zero
    - 100 blt: signed A<B
    - 101 bge: signed A≥B
    - 110 bltu: unsigned A<B
    - 111 bgeu: unsigned A≥B
    - other codes: cond = 0
  - The comparisons use the forwarded operands A and SrcB.
- When undefined: no funct3E port; PCSrcE = BranchE & Zero.

Test Plan:
- Reset: assert rst=0 mid-cycle with nonzero *M outputs → all *M outputs go to 0 immediately without a clock edge; they stay 0 until the first posedge after release.
- Add/sub with immediate:
  - RD1E=5, ImmextE=7, ALUsrcE=1, ALUcontrolE=000, RdE=3, RegwriteE=1 → next edge ALUResultM=12, RdM=3, RegwriteM=1.
  - Then ALUsrcE=0, RD2E=9, ALUcontrolE=001 → ALUResultM=32'hFFFFFFFC.
- Forwarding:
  - Prior ALUResultM=100, ForwardAE=10, ResultW=40, ForwardBE=01, add → ALUResultM=140.
  - With ALUsrcE=1, MemwriteE=1 → WriteDataM=40 (forwarded), not ImmextE.
- Branch:
  - PCE=32'h100, ImmextE=32'hFFFFFFF8, BranchE=1, ALUcontrolE=001, RD1E=RD2E=4 → PCTargetE=32'hF8, PCSrcE=1 in the same cycle.
  - RD2E=5 → PCSrcE=0.
- ALU coverage:
  - slt 32'h80000000 vs 1 → 1.
  - sll 1 by SrcB=32'h21 → 2 (uses [4:0]).
  - xor 32'hF0F0 ^ 32'h0FF0 → 32'hFF00.
  - code 111 → 0.
- BRANCH_FUNCT3_EN:
  - funct3E=110, A=32'hFFFFFFFF, B=1 → PCSrcE=0.
  - funct3E=100, same operands → PCSrcE=1.
  - funct3E=010 → PCSrcE=0.
